// File: rtl/mips_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, requester ids
// and the wait-counter width.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ID_FETCH = 1'b0,
    ID_DATA  = 1'b1
  } req_id_e;

  // Wide enough for the largest legal memory latency (15).
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Memory-access wait countdown: loads the latency on grant, counts down while
// the access is in flight and flags its final cycle.
module arb_wait_counter
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory.
// Data has priority; fetch is forced through after STARVE_MAX data grants.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  req_id_e           id_q, grant_id;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic [SW-1:0]     starve_q, starve_d;
  logic              grant, fetch_wins, busy, last;
  logic [CNT_W-1:0]  cnt;

  assign fetch_wins = i_req & (~d_req | (starve_q == STARVE_LIM));
  assign busy       = (state_q == BUSY);

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_id = fetch_wins ? ID_FETCH : ID_DATA;
    // Starvation only accumulates while fetch is actually waiting.
    starve_d = i_req ? starve_q : '0;
    unique case (state_q)
      IDLE, RESP: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (last) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      if (fetch_wins) begin
        starve_d = '0;
      end else if (i_req && (starve_q != STARVE_LIM)) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      id_q      <= ID_FETCH;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      starve_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (grant) begin
        id_q <= grant_id;
        if (grant_id == ID_FETCH) begin
          addr_q <= i_addr;
          we_q   <= 1'b0;
        end else begin
          addr_q  <= d_addr;
          we_q    <= d_we;
          wdata_q <= d_wdata;
        end
      end
      if (busy && last && !we_q) begin
        if (id_q == ID_FETCH) i_rdata_q <= m_rdata;
        else                  d_rdata_q <= m_rdata;
      end
    end
  end

  arb_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (grant),
    .load_val (CNT_W'(MEM_LAT)),
    .dec      (busy),
    .cnt      (cnt),
    .last     (last)
  );

  assign m_en    = busy;
  assign m_we    = busy & we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  assign i_valid = (state_q == RESP) && (id_q == ID_FETCH);
  assign d_valid = (state_q == RESP) && (id_q == ID_DATA);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_stall = i_req & ~i_valid;
  assign d_stall = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-port scoreboards of expected responses, a memory
// model, and directed latency / priority / starvation / reset scenarios.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned SMAX = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        we;
    logic [31:0] wdata;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  logic i_req, i_valid, i_stall;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic d_req, d_we, d_valid, d_stall;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  logic [31:0] mem [1024];
  sb_t i_q[$];
  sb_t d_q[$];
  logic [31:0] d_last;
  int total = 0;
  int bad = 0;
  int men_cnt = 0;
  int mwe_cnt = 0;

  mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .MEM_LAT    (LAT),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_valid (i_valid),
    .i_rdata (i_rdata),
    .i_stall (i_stall),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_valid (d_valid),
    .d_rdata (d_rdata),
    .d_stall (d_stall),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata)
  );

  always #5 clk = ~clk;

  assign m_rdata = mem[m_addr[11:2]];
  always @(posedge clk) if (m_en && m_we) mem[m_addr[11:2]] <= m_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hA500_0000 | {22'd0, a[11:2]};
  endfunction

  task automatic fetch_req(input logic [31:0] addr, input logic [31:0] exp, input bit keep,
                           output int lat);
    sb_t e;
    e.rdata = exp; e.we = 1'b0; e.wdata = '0;
    i_q.push_back(e);
    i_req = 1'b1; i_addr = addr; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!i_valid) check("i_stall_wait", {31'd0, i_stall}, 1);
    end while (!i_valid && lat < 100);
    if (!i_valid) check("i_timeout", 0, 1);
    else check("i_stall_valid", {31'd0, i_stall}, 0);
    if (!keep) i_req = 1'b0;
  endtask

  task automatic data_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input bit keep, output int lat);
    sb_t e;
    e.we = we; e.wdata = wdata; e.rdata = we ? d_last : exp;
    if (!we) d_last = exp;
    d_q.push_back(e);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!d_valid) check("d_stall_wait", {31'd0, d_stall}, 1);
    end while (!d_valid && lat < 100);
    if (!d_valid) check("d_timeout", 0, 1);
    else check("d_stall_valid", {31'd0, d_stall}, 0);
    if (!keep) d_req = 1'b0;
  endtask

  // Response monitor: pops the scoreboards on valid strobes.
  always @(negedge clk) begin
    sb_t e;
    if (reset) begin
      if (m_en) men_cnt++;
      if (m_we) begin
        mwe_cnt++;
        if (d_q.size() > 0) check("m_wdata", m_wdata, d_q[0].wdata);
      end
      if (i_valid && d_valid) check("both_valid", 1, 0);
      if (i_valid) begin
        if (i_q.size() == 0) check("i_spurious", 1, 0);
        else begin
          e = i_q.pop_front();
          check("i_rdata", i_rdata, e.rdata);
          check("i_men_cycles", men_cnt, LAT);
          check("i_mwe_cycles", mwe_cnt, 0);
          check("i_men_resp", {31'd0, m_en}, 0);
        end
        men_cnt = 0; mwe_cnt = 0;
      end
      if (d_valid) begin
        if (d_q.size() == 0) check("d_spurious", 1, 0);
        else begin
          e = d_q.pop_front();
          check("d_rdata", d_rdata, e.rdata);
          check("d_men_cycles", men_cnt, LAT);
          check("d_mwe_cycles", mwe_cnt, e.we ? LAT : 0);
        end
        men_cnt = 0; mwe_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, lf;
    int ld[5];
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    mem[32'h40 >> 2]  = 32'h8C01_0004;
    mem[32'h100 >> 2] = 32'h1234_5678;
    d_last = '0;
    reset = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_m_en", {31'd0, m_en}, 0);
    check("rst_valids", {30'd0, i_valid, d_valid}, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_m_addr", m_addr, 0);
    reset = 1'b1;
    @(negedge clk);

    // Isolated fetch
    fetch_req(32'h40, 32'h8C01_0004, 1'b0, lat);
    check("t1_lat", lat, LAT + 1);

    // Simultaneous requests: data first, fetch one access later
    fork
      fetch_req(32'h44, pat(32'h44), 1'b0, lf);
      data_req(1'b0, 32'h100, '0, 32'h1234_5678, 1'b0, ld[0]);
    join
    check("t2_d_lat", ld[0], LAT + 1);
    check("t2_i_lat", lf, 2 * (LAT + 1));
    @(negedge clk);

    // Starvation: fetch forced through after STARVE_MAX data grants
    fork
      fetch_req(32'h48, pat(32'h48), 1'b0, lf);
      for (int k = 0; k < 5; k++) begin
        logic [31:0] a;
        a = 32'h100 + 32'(4 * k);
        data_req(1'b0, a, '0, (k == 0) ? 32'h1234_5678 : pat(a), k < 4, ld[k]);
      end
    join
    check("t3_i_lat", lf, (SMAX + 1) * (LAT + 1));
    check("t3_d0_lat", ld[0], LAT + 1);
    check("t3_d3_lat", ld[3], LAT + 1);
    check("t3_d4_lat", ld[4], 2 * (LAT + 1));
    @(negedge clk);

    // Write, then read it back
    data_req(1'b1, 32'h200, 32'hDEAD_BEEF, '0, 1'b0, lat);
    check("t4_w_lat", lat, LAT + 1);
    data_req(1'b0, 32'h200, '0, 32'hDEAD_BEEF, 1'b0, lat);
    check("t4_rb_lat", lat, LAT + 1);

    // Reset in the first BUSY cycle aborts the access
    i_req = 1'b1; i_addr = 32'h40;
    @(posedge clk);
    #2 reset = 1'b0;
    i_req = 1'b0;
    #1;
    check("t5_m_en_async", {31'd0, m_en}, 0);
    check("t5_valid", {30'd0, i_valid, d_valid}, 0);
    check("t5_i_rdata", i_rdata, 0);
    repeat (2) @(negedge clk);
    check("t5_held_m_en", {31'd0, m_en}, 0);
    reset = 1'b1;
    d_last = '0;
    men_cnt = 0; mwe_cnt = 0;
    @(negedge clk);
    check("t5_idle_m_en", {31'd0, m_en}, 0);
    check("t5_idle_valid", {30'd0, i_valid, d_valid}, 0);
    fetch_req(32'h40, 32'h8C01_0004, 1'b0, lat);
    check("t5_resub_lat", lat, LAT + 1);
    @(negedge clk);

    // Back-to-back fetches with i_req held through each valid
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      a = 32'h300 + 32'(4 * k);
      fetch_req(a, pat(a), k < 3, lat);
      check("t6_lat", lat, LAT + 1);
    end
    repeat (3) @(negedge clk);
    check("end_i_q_empty", i_q.size(), 0);
    check("end_d_q_empty", d_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MEM_LAT, default 2, memory access cycles (legal range 1..15).
REQ-004 Parameter STARVE_MAX, default 4, consecutive data grants allowed while fetch waits.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (reset=0 clears).
REQ-007 i_req  in  1  fetch request; i_addr  in  ADDR_W  fetch address.
REQ-008 i_valid  out  1  fetch response strobe; i_rdata  out  DATA_W  fetched word; i_stall  out  1  fetch waiting.
REQ-009 d_req  in  1, d_we  in  1, d_addr  in  ADDR_W, d_wdata  in  DATA_W  data-stage request.
REQ-010 d_valid  out  1, d_rdata  out  DATA_W, d_stall  out  1  data-stage response and stall.
REQ-011 m_en  out  1, m_we  out  1, m_addr  out  ADDR_W, m_wdata  out  DATA_W, m_rdata  in  DATA_W  shared single-port memory.

Function
REQ-012 FSM states IDLE, BUSY, RESP; arbitration occurs on edges leaving IDLE or RESP.
REQ-013 Requesters hold req and operands stable until their valid strobe; req high during its own valid cycle means a new access.
REQ-014 Arbitration: data wins over fetch, unless starve_cnt==STARVE_MAX and i_req=1, then fetch wins.
REQ-015 starve_cnt increments on each data grant while i_req=1, saturates at STARVE_MAX, clears on any fetch grant or when i_req=0.
REQ-016 On grant, latch winner id, address, we, wdata; load wait counter with MEM_LAT; go BUSY.
REQ-017 In BUSY: m_en=1, m_addr/m_we/m_wdata driven from latched values; counter decrements each edge.
REQ-018 Edge with counter==1 in BUSY: capture m_rdata into the winner's rdata register (reads only), go RESP.
REQ-019 BUSY lasts exactly MEM_LAT cycles; valid asserted in the cycle MEM_LAT+1 edges after the grant edge.
REQ-020 RESP: winner's valid=1 for exactly one cycle; m_en=0; next state BUSY if any req (re-arbitrated), else IDLE.
REQ-021 Writes: d_valid pulses as for reads; d_rdata retains its previous value.
REQ-022 i_rdata/d_rdata hold last captured value until next read of that port.
REQ-023 i_stall = i_req & ~i_valid; d_stall = d_req & ~d_valid (combinational).
REQ-024 m_en, m_we = 0 in IDLE and RESP; m_addr/m_wdata hold last value.
REQ-025 Simultaneous i_req and d_req in same cycle: one grant only; loser stays stalled, served at next arbitration.

Reset
REQ-026 reset=0 immediately forces IDLE, counters to 0, all outputs to 0, regardless of clock.
REQ-027 Reset mid-BUSY aborts the access: no valid strobe issued, m_en drops asynchronously.
REQ-028 First arbitration occurs on the first rising edge with reset=1.

Structure
REQ-029 State encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and requester ids (ID_FETCH=0, ID_DATA=1) reside in shared package mips_pkg.
REQ-030 Wait countdown implemented in sub-module arb_wait_counter (load, decrement, last flag).

Verification
REQ-031 MEM_LAT=2, i_req addr 0x40, mem[0x40]=0x8C010004 -> m_en high 2 cycles, i_valid 3 edges after grant, i_rdata=0x8C010004.
REQ-032 i_req and d_req (read 0x100=0x12345678) same cycle -> data served first, d_rdata=0x12345678, fetch valid 3 cycles later.
REQ-033 d_req held continuously, i_req high, STARVE_MAX=4 -> fetch granted after 4th data grant.
REQ-034 d_we=1, addr 0x200, wdata 0xDEADBEEF -> m_we=1 for 2 cycles with m_wdata=0xDEADBEEF, d_valid pulse, d_rdata unchanged.
REQ-035 reset=0 during BUSY cycle 1 -> m_en=0 immediately, no valid, IDLE after release; resubmitted request completes normally.
REQ-036 Back-to-back fetches (i_req held through i_valid) -> next BUSY begins cycle after RESP, i_stall low only in valid cycles.
